feature_line_buffer: RTL
========================

Name: feature_line_buffer

Overview:
- Upstream feeder for the convolution layer processor (CLP); converts a raster-scan stream of T_n-channel feature pixels into KERNEL_SIZE-tall vertical columns.
- Drives the CLP `feature_in` bus and `feature_in_ready` shift strobe, one column per accepted pixel.
- Flags when the CLP's KxK shift window holds a complete, in-image window (`win_valid`) and marks end of frame.

Parameters:
- T_n, 2: parallel input channels.
- KERNEL_SIZE, 5: window height/width K; must be >= 2.
- FEATURE_IN_WIDTH, 8: bits per pixel per channel.
- IMG_W, 28: pixels per line; must be >= K.
- IMG_H, 28: lines per frame; must be >= K.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  synchronous, active-high reset (asserted = 1 despite name).
- pix_in  in  T_n*FEATURE_IN_WIDTH  channel n at bits [n*W +: W].
- pix_valid  in  1  pixel present.
- pix_ready  out  1  = ~stall.
- stall  in  1  downstream controller hold.
- col_out  out  T_n*K*FEATURE_IN_WIDTH  channel n row i at [(n*K+i)*W +: W]; row 0 = oldest line, row K-1 = current pixel.
- feature_in_ready  out  1  column strobe; 1-cycle pulse with col_out.
- win_valid  out  1  CLP window now complete (qualifies strobe cycle).
- out_row  out  clog2(IMG_H)  image row of the emitted pixel.
- out_col  out  clog2(IMG_W)  image column of the emitted pixel.
- frame_done  out  1  pulse with the last pixel's column.

Behaviour:
- Accept = pix_valid & pix_ready. No action otherwise; outputs hold except the strobes, which drop to 0.
- Counters c (0..IMG_W-1) and r (0..IMG_H-1) track the accepted pixel.
  - c wraps to 0 and r increments at c = IMG_W-1.
  - At (IMG_H-1, IMG_W-1), both clear to 0.
- Line memory holds K-1 lines of IMG_W entries per channel, organised as a circular line pointer.
  - On accept: read K-1 stored entries at column c, write the new pixel at column c into the oldest line slot.
  - The pointer advances on line wrap.
  - Read-before-write at the same address is required.
- Column assembly: row i holds the pixel at image (r-K+1+i, c).
  - Rows with r-K+1+i < 0 are forced to 0.
  - col_out is registered; latency is 1 cycle from accept.
- FSM, 2 states:
  - FILL (r < K-1): stores pixels only; feature_in_ready stays 0.
  - STREAM (r >= K-1): feature_in_ready = 1 the cycle after each accept.
  - FILL -> STREAM on line wrap when r = K-2.
  - STREAM -> FILL on the last pixel of the frame.
- win_valid = feature_in_ready & (emitted c >= K-1).
- frame_done = 1 with the column of pixel (IMG_H-1, IMG_W-1).
- stall asserted while pix_valid = 1: no accept, no memory write, counters frozen.
- Reset values: all outputs 0; counters 0; state FILL; line pointer 0. Memory is not cleared; zero-masking covers stale data.
- Reset mid-frame: the next accepted pixel is (0,0) and the partial frame is discarded.
- Back-to-back accepts on consecutive cycles are fully supported; throughput is 1 pixel/clk.

Optional Feature:
- Macro: SOF_SYNC_EN.
- Defined:
  - Adds input port `sof` (1 bit).
  - An accepted pixel with sof = 1 is treated as (0,0): counters and line pointer reload, state goes to FILL.
  - sof on a pixel already at (0,0) has no side effect.
  - Adds output `sof_err` (1 bit, registered): pulses when sof arrives with counters != (0,0).
- Not defined: no `sof` or `sof_err` ports; counters free-run from reset.

Decomposition:
- Shared package: FEATURE_IN_WIDTH, KERNEL_SIZE, T_n, the column-bus width function, and the FSM state encoding (FILL = 0, STREAM = 1).
- One sub-module, `line_ram`: single-clock, read-before-write RAM of depth IMG_W and width (K-1)*T_n*FEATURE_IN_WIDTH, with a registered read.
- The top level holds the counters, FSM, pointer rotation and masking.

Test Plan:
Parameters for all scenarios: T_n=1, K=3, IMG_W=IMG_H=6, pixel = r*16+c.
- Full frame, pix_valid continuously 1:
  - No strobe for the first 12 accepts.
  - Pixel (2,0) -> col_out rows {0x00,0x10,0x20}, strobe = 1, win_valid = 0.
  - Pixel (2,2) -> rows {0x02,0x12,0x22}, win_valid = 1.
  - Total of 16 win_valid pulses.
- Last pixel (5,5) -> rows {0x35,0x45,0x55}, frame_done = 1.
  - The next frame's (0,0) gives no strobe: state is back in FILL.
- stall = 1 for 3 cycles mid-line at (3,2) with pix_valid = 1:
  - pix_ready = 0, no strobe, counters hold.
  - After release, (3,2) is emitted once with correct rows.
- Reset asserted after pixel (4,1):
  - Outputs 0 on the next cycle.
  - A new frame reproduces exactly the scenario-1 sequence with zero stale data.
- Random pix_valid gaps (~30% idle): the column sequence is identical to scenario 1; strobes occur only on accept+1.
- SOF_SYNC_EN defined, sof pulsed at pixel index 20 (row 3, col 2):
  - sof_err = 1.
  - The next 12 accepts produce no strobe, then streaming restarts at image row 2.

Source files
------------

// File: rtl/feature_line_buffer_pkg.sv
// Shared constants, FSM encoding and bus-width helper for the CLP feature line buffer.
// Optional start-of-frame resync is enabled with SOF_SYNC_EN.
package feature_line_buffer_pkg;

    localparam int T_n              = 2;
    localparam int KERNEL_SIZE      = 5;
    localparam int FEATURE_IN_WIDTH = 8;

    typedef enum logic {
        FILL   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // Width of the assembled column bus: every channel carries K rows.
    function automatic int col_bus_w(input int tn, input int k, input int w);
        return tn * k * w;
    endfunction

endpackage

// File: rtl/feature_line_buffer_if.sv
// Pixel-in / column-out bundle between the raster source, line buffer and CLP.
// With SOF_SYNC_EN defined the bundle also carries sof / sof_err.
interface feature_line_buffer_if #(
    parameter int T_n              = feature_line_buffer_pkg::T_n,
    parameter int KERNEL_SIZE      = feature_line_buffer_pkg::KERNEL_SIZE,
    parameter int FEATURE_IN_WIDTH = feature_line_buffer_pkg::FEATURE_IN_WIDTH,
    parameter int IMG_W            = 28,
    parameter int IMG_H            = 28
);
    localparam int PIX_W = T_n * FEATURE_IN_WIDTH;
    localparam int COL_W = feature_line_buffer_pkg::col_bus_w(T_n, KERNEL_SIZE, FEATURE_IN_WIDTH);
    localparam int RW    = $clog2(IMG_H);
    localparam int CW    = $clog2(IMG_W);

    logic [PIX_W-1:0] pix_in;
    logic             pix_valid;
    logic             pix_ready;
    logic             stall;
    logic [COL_W-1:0] col_out;
    logic             feature_in_ready;
    logic             win_valid;
    logic [RW-1:0]    out_row;
    logic [CW-1:0]    out_col;
    logic             frame_done;
`ifdef SOF_SYNC_EN
    logic             sof;
    logic             sof_err;

    modport master (output pix_in, pix_valid, stall, sof,
                    input  pix_ready, col_out, feature_in_ready, win_valid,
                           out_row, out_col, frame_done, sof_err);
    modport slave  (input  pix_in, pix_valid, stall, sof,
                    output pix_ready, col_out, feature_in_ready, win_valid,
                           out_row, out_col, frame_done, sof_err);
`else
    modport master (output pix_in, pix_valid, stall,
                    input  pix_ready, col_out, feature_in_ready, win_valid,
                           out_row, out_col, frame_done);
    modport slave  (input  pix_in, pix_valid, stall,
                    output pix_ready, col_out, feature_in_ready, win_valid,
                           out_row, out_col, frame_done);
`endif

endinterface

// File: rtl/feature_line_buffer_line_ram.sv
// Line memory: one read-before-write bank per line slot, shared column address,
// registered read that only updates on an enabled (accepted) cycle.
module line_ram #(
    parameter int DEPTH  = 28,
    parameter int SLOTS  = 4,
    parameter int SLOT_W = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    en,
    input  logic [SLOTS-1:0]        we,
    input  logic [AW-1:0]           addr,
    input  logic [SLOT_W-1:0]       wdata,
    output logic [SLOTS*SLOT_W-1:0] rdata
);

    for (genvar s = 0; s < SLOTS; s++) begin : g_slot
        logic [SLOT_W-1:0] mem [DEPTH];
        logic [SLOT_W-1:0] rdata_q;

        // Old contents are read out before the same address is overwritten.
        always_ff @(posedge clk) begin
            if (en) begin
                rdata_q <= mem[addr];
                if (we[s]) mem[addr] <= wdata;
            end
        end

        assign rdata[s*SLOT_W +: SLOT_W] = rdata_q;
    end

endmodule

// File: rtl/feature_line_buffer.sv
// Raster-to-column converter feeding the CLP feature_in bus.
// Build option SOF_SYNC_EN: sof input resyncs the frame position, sof_err flags a misaligned sof.
module feature_line_buffer #(
    parameter int T_n              = feature_line_buffer_pkg::T_n,
    parameter int KERNEL_SIZE      = feature_line_buffer_pkg::KERNEL_SIZE,
    parameter int FEATURE_IN_WIDTH = feature_line_buffer_pkg::FEATURE_IN_WIDTH,
    parameter int IMG_W            = 28,
    parameter int IMG_H            = 28
) (
    input  logic                  clk,
    input  logic                  rst_n,  // active-high synchronous reset
    feature_line_buffer_if.slave  bus
);
    import feature_line_buffer_pkg::*;

    localparam int K     = KERNEL_SIZE;
    localparam int W     = FEATURE_IN_WIDTH;
    localparam int PIX_W = T_n * W;
    localparam int COL_W = col_bus_w(T_n, K, W);
    localparam int SLOTS = K - 1;
    localparam int RW    = $clog2(IMG_H);
    localparam int CW    = $clog2(IMG_W);
    localparam int PW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    logic [CW-1:0]    c_q, c_d, c_eff;
    logic [RW-1:0]    r_q, r_d, r_eff;
    logic [PW-1:0]    ptr_q, ptr_d, ptr_eff;
    state_t           state_q, state_d, state_eff;
    logic [PIX_W-1:0] pix_q, pix_d;
    logic [PW-1:0]    eptr_q, eptr_d;
    logic [K-1:0]     mask_q, mask_d;
    logic [RW-1:0]    row_q, row_d;
    logic [CW-1:0]    col_q, col_d;
    logic             strobe_q, strobe_d;
    logic             win_q, win_d;
    logic             done_q, done_d;

    logic                   accept, sof_hit, line_end, frame_end;
    logic [SLOTS-1:0]       ram_we;
    logic [SLOTS*PIX_W-1:0] ram_rdata;
    logic [COL_W-1:0]       col_out;

    assign accept = bus.pix_valid & ~bus.stall;

`ifdef SOF_SYNC_EN
    logic sof_err_q, sof_err_d;
    assign sof_hit = accept & bus.sof;
`else
    assign sof_hit = 1'b0;
`endif

    // An sof pixel is processed as if the position state were already at (0,0) in FILL.
    assign c_eff     = sof_hit ? '0 : c_q;
    assign r_eff     = sof_hit ? '0 : r_q;
    assign ptr_eff   = sof_hit ? '0 : ptr_q;
    assign state_eff = sof_hit ? FILL : state_q;
    assign line_end  = (c_eff == CW'(IMG_W - 1));
    assign frame_end = line_end && (r_eff == RW'(IMG_H - 1));

    // Raster position and line-slot pointer; everything frozen unless a pixel is accepted.
    always_comb begin
        c_d   = c_q;
        r_d   = r_q;
        ptr_d = ptr_q;
        if (accept) begin
            if (line_end) begin
                c_d   = '0;
                r_d   = frame_end ? '0 : r_eff + 1'b1;
                ptr_d = (ptr_eff == PW'(SLOTS - 1)) ? '0 : ptr_eff + 1'b1;
            end else begin
                c_d   = c_eff + 1'b1;
                r_d   = r_eff;
                ptr_d = ptr_eff;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst_n) state_q <= FILL;
        else       state_q <= state_d;
    end

    // FSM next state: stream once K-1 lines are buffered, refill at each new frame.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = state_eff;
            if (state_eff == FILL && line_end && r_eff == RW'(K - 2)) state_d = STREAM;
            else if (state_eff == STREAM && frame_end)                 state_d = FILL;
        end
    end

    // FSM outputs: capture everything needed to present the column one cycle after accept.
    always_comb begin
        pix_d    = pix_q;
        eptr_d   = eptr_q;
        mask_d   = mask_q;
        row_d    = row_q;
        col_d    = col_q;
        strobe_d = 1'b0;
        win_d    = 1'b0;
        done_d   = 1'b0;
`ifdef SOF_SYNC_EN
        sof_err_d = sof_hit && (c_q != '0 || r_q != '0);
`endif
        if (accept) begin
            pix_d  = bus.pix_in;
            eptr_d = ptr_eff;
            row_d  = r_eff;
            col_d  = c_eff;
            // Row i is image line r-K+1+i; lines above the frame top are masked to zero.
            for (int i = 0; i < K; i++) mask_d[i] = (int'(r_eff) + i) >= (K - 1);
            strobe_d = (state_eff == STREAM);
            win_d    = (state_eff == STREAM) && (c_eff >= CW'(K - 1));
            done_d   = frame_end;
        end
    end

    // Datapath and counter registers.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            c_q      <= '0;
            r_q      <= '0;
            ptr_q    <= '0;
            pix_q    <= '0;
            eptr_q   <= '0;
            mask_q   <= '0;
            row_q    <= '0;
            col_q    <= '0;
            strobe_q <= 1'b0;
            win_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            c_q      <= c_d;
            r_q      <= r_d;
            ptr_q    <= ptr_d;
            pix_q    <= pix_d;
            eptr_q   <= eptr_d;
            mask_q   <= mask_d;
            row_q    <= row_d;
            col_q    <= col_d;
            strobe_q <= strobe_d;
            win_q    <= win_d;
            done_q   <= done_d;
        end
    end

`ifdef SOF_SYNC_EN
    // Misaligned-sof flag register.
    always_ff @(posedge clk) begin
        if (rst_n) sof_err_q <= 1'b0;
        else       sof_err_q <= sof_err_d;
    end
    assign bus.sof_err = sof_err_q;
`endif

    // New pixel overwrites the oldest line slot at the current column.
    always_comb begin
        ram_we = '0;
        for (int s = 0; s < SLOTS; s++) ram_we[s] = accept && (ptr_eff == PW'(s));
    end

    line_ram #(
        .DEPTH  (IMG_W),
        .SLOTS  (SLOTS),
        .SLOT_W (PIX_W),
        .AW     (CW)
    ) u_line_ram (
        .clk   (clk),
        .en    (accept),
        .we    (ram_we),
        .addr  (c_eff),
        .wdata (bus.pix_in),
        .rdata (ram_rdata)
    );

    // Column assembly: slot (eptr+i) mod (K-1) holds image line r-K+1+i.
    always_comb begin
        int s;
        s       = 0;
        col_out = '0;
        for (int n = 0; n < T_n; n++) begin
            for (int i = 0; i < SLOTS; i++) begin
                s = int'(eptr_q) + i;
                if (s >= SLOTS) s = s - SLOTS;
                if (mask_q[i]) col_out[(n*K + i)*W +: W] = ram_rdata[(s*T_n + n)*W +: W];
            end
            if (mask_q[K-1]) col_out[(n*K + K - 1)*W +: W] = pix_q[n*W +: W];
        end
    end

    assign bus.pix_ready        = ~bus.stall;
    assign bus.col_out          = col_out;
    assign bus.feature_in_ready = strobe_q;
    assign bus.win_valid        = win_q;
    assign bus.frame_done       = done_q;
    assign bus.out_row          = row_q;
    assign bus.out_col          = col_q;

endmodule
